pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register that succeeds the fixed-width stall/clear stage registers between CPU pipeline stages. It carries a DATA_W-bit payload, for example a packed {pc, instr, pc4}, under a valid/ready handshake. A 2-entry skid buffer keeps in_ready registered, which breaks the combinational stall path between neighbouring stages. Flush is the highest-priority event; one instance sits between each pair of stages (F/D, D/E, E/M, M/W).

Parameters:
DATA_W, 96, payload width in bits.
FLUSH_ZERO, 1, 1 = payload registers forced to 0 on flush (instr 0 acts as nop); 0 = payload held, only valid bits cleared.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept; registered, equals !skid_valid
in_data  input  DATA_W  upstream payload
flush  input  1  discard all held entries this cycle
out_valid  output  1  out_data valid; equals main_valid
out_ready  input  1  downstream accepts
out_data  output  DATA_W  main entry payload
occ  output  2  number of held entries: 0, 1 or 2
stall_cnt  output  CNT_W  present only with PIPE_STAGE_PERF_EN
bubble_cnt  output  CNT_W  present only with PIPE_STAGE_PERF_EN

Behaviour:
- Storage: main entry {main_valid, main_data} and skid entry {skid_valid, skid_data}. occ encoding: EMPTY=0, ONE=1, FULL=2.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (reset=0, async): both valid bits 0; both data registers 0; in_ready=1; out_valid=0; occ=0; counters 0.
- Transitions with flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise stay EMPTY.
  - ONE: in_fire & out_fire -> ONE, main<=in_data.
  - ONE: in_fire & !out_fire -> FULL, skid<=in_data.
  - ONE: !in_fire & out_fire -> EMPTY.
  - ONE: neither fires -> hold.
  - FULL: in_ready=0, so in_fire cannot occur. out_fire -> ONE, main<=skid_data. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. An entry that has passed through the skid buffer has 2+ cycles latency.
- Ordering: strict FIFO. The skid entry never overtakes main.
- flush=1 (any state): next state EMPTY, both valid bits 0.
  - Any in_fire in the same cycle is discarded; upstream counts it as consumed.
  - Any out_fire in the same cycle still counts as delivered to downstream.
  - FLUSH_ZERO=1: main_data and skid_data <= 0. FLUSH_ZERO=0: data registers hold.
- Data registers only load on the transitions above; they never change while holding.
- out_data while out_valid=0 is main_data as stored: 0 after reset or a zeroing flush, otherwise stale.
- Reset asserted mid-transfer: state is lost immediately and asynchronously; the first accept after release goes to EMPTY->ONE.
- Full throughput: with in_valid=1 and out_ready=1 held, one transfer per cycle and occ stays 1.

Optional Feature:
PIPE_STAGE_PERF_EN.
- Defined: stall_cnt and bubble_cnt ports and counters exist.
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0.
  - Both saturate at 2^CNT_W-1, clear only on reset, and are unaffected by flush.
- Not defined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
1. Reset held low 3 cycles then released; in_valid=1 with in_data=0x...A5, out_ready=1 -> out_valid=1 next cycle with out_data=0x...A5; occ=1; in_ready stays 1.
2. Stream 5 words D0..D4 with out_ready=1 -> D0..D4 emerge on consecutive cycles, 1-cycle latency, occ constant 1.
3. out_ready=0 from cycle 2 with in_valid=1 continuously -> occ goes 1 then 2; in_ready=0 one cycle later; out_data holds D0. Then out_ready=1 -> D0, D1, D2 in order with none lost or duplicated; in_ready back to 1 the cycle after the first out_fire.
4. State FULL, then flush=1 together with in_valid=1 (FLUSH_ZERO=1) -> next cycle occ=0, out_valid=0, out_data=0, in_ready=1, and the flush-cycle input never appears. Repeat with FLUSH_ZERO=0 -> out_data keeps its old value.
5. Assert reset for half a cycle while occ=2, with no clock edge -> out_valid and in_ready change immediately to 0 and 1.
6. PIPE_STAGE_PERF_EN defined, CNT_W=4; hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); a flush afterwards leaves stall_cnt=15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with a 2-entry skid
// buffer so that in_ready comes straight from a flop.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered, == !skid_valid)
//   in_data    upstream payload, DATA_W bits
//   flush      discard all held entries this cycle (highest priority)
//   out_valid  out_data valid (== main_valid)
//   out_ready  downstream accepts
//   out_data   main entry payload
//   occ        held entries: 0, 1 or 2
//   stall_cnt  cycles with out_valid & !out_ready  (PIPE_STAGE_PERF_EN only)
//   bubble_cnt cycles with !out_valid              (PIPE_STAGE_PERF_EN only)
//
// Parameters:
//   DATA_W      payload width
//   FLUSH_ZERO  1: flush zeroes both data registers; 0: data held
//   CNT_W       performance counter width (PIPE_STAGE_PERF_EN only)
//
// Optional feature macro: PIPE_STAGE_PERF_EN adds the saturating counters.

module pipe_stage_skid #(
  parameter int DATA_W     = 96,
  parameter int FLUSH_ZERO = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic [1:0]        occ
);

  // The state value doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  // Valid bits are decoded from the state flop, so in_ready and out_valid
  // have no combinational path from any input.
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign occ       = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Same-cycle in_fire is dropped; same-cycle out_fire was delivered.
      state_d = EMPTY;
      if (FLUSH_ZERO != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (out_fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating; flush deliberately does not touch the counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!out_valid && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid. Two instances share all inputs: dut_z
// zeroes data on flush, dut_h holds data on flush.

module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;

  logic          z_in_ready, h_in_ready;
  logic          z_out_valid, h_out_valid;
  logic [DW-1:0] z_out_data, h_out_data;
  logic [1:0]    z_occ, h_occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] z_stall, h_stall, z_bubble, h_bubble;
`endif

  int total;
  int bad;

  pipe_stage_skid #(.DATA_W(DW), .FLUSH_ZERO(1), .CNT_W(CW)) dut_z (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (z_in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (z_out_valid),
    .out_ready (out_ready),
    .out_data  (z_out_data),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (z_stall),
    .bubble_cnt(z_bubble),
`endif
    .occ       (z_occ)
  );

  pipe_stage_skid #(.DATA_W(DW), .FLUSH_ZERO(0), .CNT_W(CW)) dut_h (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (h_in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (h_out_valid),
    .out_ready (out_ready),
    .out_data  (h_out_data),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (h_stall),
    .bubble_cnt(h_bubble),
`endif
    .occ       (h_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic ir,
                           input logic [1:0] oc, input logic [DW-1:0] od);
    check({tag, ".out_valid"}, 32'(z_out_valid), 32'(ov));
    check({tag, ".in_ready"},  32'(z_in_ready),  32'(ir));
    check({tag, ".occ"},       32'(z_occ),       32'(oc));
    check({tag, ".out_data"},  32'(z_out_data),  32'(od));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // 1: reset for 3 cycles, then first transfer.
    tick(); tick(); tick();
    chk_state("rst", 1'b0, 1'b1, 2'd0, 16'h0000);
    check("rst.h_out_data", 32'(h_out_data), 32'h0);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h00A5;
    out_ready = 1'b1;
    tick();
    chk_state("first", 1'b1, 1'b1, 2'd1, 16'h00A5);
    in_valid = 1'b0;
    tick();
    chk_state("drain1", 1'b0, 1'b1, 2'd0, 16'h00A5);

    // 2: stream five words at full throughput.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h1000 + 16'(i);
      tick();
      chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 16'h1000 + 16'(i));
    end
    in_valid = 1'b0;
    tick();
    chk_state("stream_end", 1'b0, 1'b1, 2'd0, 16'h1004);

    // 3: backpressure fills the skid entry, then drain in order.
    in_valid  = 1'b1;
    in_data   = 16'hE000;
    out_ready = 1'b0;
    tick();
    chk_state("bp_one", 1'b1, 1'b1, 2'd1, 16'hE000);
    in_data = 16'hE001;
    tick();
    chk_state("bp_full", 1'b1, 1'b0, 2'd2, 16'hE000);
    in_data = 16'hE002;
    tick();
    chk_state("bp_hold", 1'b1, 1'b0, 2'd2, 16'hE000);
    out_ready = 1'b1;
    tick();
    chk_state("bp_drain1", 1'b1, 1'b1, 2'd1, 16'hE001);
    tick();
    chk_state("bp_drain2", 1'b1, 1'b1, 2'd1, 16'hE002);
    in_valid = 1'b0;
    tick();
    chk_state("bp_empty", 1'b0, 1'b1, 2'd0, 16'hE002);

    // 4: flush from FULL together with an incoming word.
    in_valid  = 1'b1;
    in_data   = 16'hF000;
    out_ready = 1'b0;
    tick();
    in_data = 16'hF001;
    tick();
    chk_state("fl_full", 1'b1, 1'b0, 2'd2, 16'hF000);
    flush   = 1'b1;
    in_data = 16'hF002;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_state("fl_zero", 1'b0, 1'b1, 2'd0, 16'h0000);
    check("fl_hold.out_data", 32'(h_out_data), 32'hF000);
    check("fl_hold.occ", 32'(h_occ), 32'd0);
    tick();
    chk_state("fl_after", 1'b0, 1'b1, 2'd0, 16'h0000);
    // Flush in EMPTY drops a simultaneous accept.
    in_valid = 1'b1;
    in_data  = 16'hF003;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_empty.occ", 32'(z_occ), 32'd0);
    check("fl_empty.h_out_data", 32'(h_out_data), 32'hF000);

    // 5: asynchronous reset between edges while FULL.
    in_valid = 1'b1;
    in_data  = 16'h2000;
    tick();
    in_data = 16'h2001;
    tick();
    check("ar_pre.occ", 32'(z_occ), 32'd2);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_state("ar", 1'b0, 1'b1, 2'd0, 16'h0000);
    check("ar.h_out_data", 32'(h_out_data), 32'h0);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h3000;
    out_ready = 1'b1;
    tick();
    chk_state("ar_after", 1'b1, 1'b1, 2'd1, 16'h3000);
    in_valid = 1'b0;
    tick();

`ifdef PIPE_STAGE_PERF_EN
    // 6: counters saturate and ignore flush.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h4000;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("perf.bubble0", 32'(z_bubble), 32'd1);
    check("perf.stall0", 32'(z_stall), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("perf.stall_sat", 32'(z_stall), 32'd15);
    check("perf.bubble_keep", 32'(z_bubble), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf.flush_stall", 32'(z_stall), 32'd15);
    tick();
    check("perf.flush_bubble", 32'(z_bubble), 32'd2);
    check("perf.h_stall", 32'(h_stall), 32'd15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
